// File: rtl/fmap_buf_reader.sv
// fmap_buf_reader: streams one frame of NUM_WORDS feature-map words out of
// RAM port B, starting at BASE_ADDR. Reads are issued only when the output
// FIFO is guaranteed to have room once they land. This means back-pressure
// on the valid/ready stream never drops data.
module fmap_buf_reader #(
    parameter int DATA_WIDTH      = 16,
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int NUM_WORDS       = 784,
    parameter int BASE_ADDR       = 0,
    parameter int RD_LATENCY      = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rden_b,
    output logic                       wren_b,
    output logic [POOL_ADDR_WIDTH-1:0] address_b_t,
    input  logic [DATA_WIDTH-1:0]      q_b,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    input  logic                       data_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W  = $clog2(NUM_WORDS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]           LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam logic [PTR_W-1:0]           LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [POOL_ADDR_WIDTH-1:0] BASE      = POOL_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [FCNT_W:0]            DEPTH_LIM = (FCNT_W + 1)'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      pop_cnt;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FCNT_W-1:0]     fifo_count;
    logic [FCNT_W-1:0]     inflight;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;

    assign wren_b     = 1'b0;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign push       = rd_pipe[RD_LATENCY-1];
    assign data_valid = (fifo_count != '0);
    assign pop        = data_valid && data_ready;
    assign data_out   = data_valid ? fifo_mem[rd_ptr] : '0;

    // Every word either waiting in the FIFO or still in flight owns a slot.
    // This keeps the FIFO from overflowing. A pop happening in the same
    // cycle is deliberately not credited.
    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_LIM;
    assign rden_b     = (state == S_ISSUE) && credit_ok;

    // Count reads that are issued but whose data has not yet reached the FIFO
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + FCNT_W'(rd_pipe[i]);
        end
    end

    // Frame sequencing: issue addresses, then wait for the sink to drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            address_b_t <= BASE;
            issue_cnt   <= '0;
            pop_cnt     <= '0;
        end else begin
            if (pop) begin
                pop_cnt <= pop_cnt + CNT_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        address_b_t <= BASE;
                        issue_cnt   <= '0;
                        pop_cnt     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (rden_b) begin
                        address_b_t <= address_b_t + POOL_ADDR_WIDTH'(1);
                        issue_cnt   <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == LAST_IDX) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && (pop_cnt == LAST_IDX)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Track each issued read until its data appears on q_b
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= rden_b;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage captures returning RAM data
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= q_b;
        end
    end

endmodule

// File: tb/tb_fmap_buf_reader.sv
// Bench for fmap_buf_reader. It uses two instances:
//   A: NUM_WORDS=8, BASE_ADDR=0, 10-bit addresses, RAM holds mem[i]=i+100.
//   B: NUM_WORDS=4, BASE_ADDR=14, 4-bit addresses (wrap case), mem[i]=3*i+7.
module tb_fmap_buf_reader;

    localparam int N_A    = 8;
    localparam int BASE_A = 0;
    localparam int DEPTH  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a, ready_a, start_b, ready_b;

    logic        busy_a, done_a, rden_a, wren_a, valid_a;
    logic [9:0]  addr_a;
    logic [15:0] q_a, data_a;

    logic        busy_b, done_b, rden_b2, wren_b2, valid_b;
    logic [3:0]  addr_b;
    logic [15:0] q_b2, data_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    fmap_buf_reader #(
        .DATA_WIDTH(16), .POOL_ADDR_WIDTH(10), .NUM_WORDS(N_A),
        .BASE_ADDR(BASE_A), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .busy(busy_a),
        .done(done_a), .rden_b(rden_a), .wren_b(wren_a),
        .address_b_t(addr_a), .q_b(q_a), .data_out(data_a),
        .data_valid(valid_a), .data_ready(ready_a)
    );

    fmap_buf_reader #(
        .DATA_WIDTH(16), .POOL_ADDR_WIDTH(4), .NUM_WORDS(4),
        .BASE_ADDR(14), .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .busy(busy_b),
        .done(done_b), .rden_b(rden_b2), .wren_b(wren_b2),
        .address_b_t(addr_b), .q_b(q_b2), .data_out(data_b),
        .data_valid(valid_b), .data_ready(ready_b)
    );

    // RAM models with two-cycle read latency; non-read cycles return junk
    logic [15:0] ram_a [1024];
    logic [15:0] ram_b [16];
    logic [15:0] rpa0, rpa1, rpb0, rpb1;
    initial begin
        for (int i = 0; i < 1024; i++) ram_a[i] = 16'(i + 100);
        for (int i = 0; i < 16; i++)   ram_b[i] = 16'(3 * i + 7);
    end
    always @(posedge clock) begin
        rpa0 <= rden_a  ? ram_a[addr_a] : 16'hDEAD;
        rpa1 <= rpa0;
        rpb0 <= rden_b2 ? ram_b[addr_b] : 16'hBEEF;
        rpb1 <= rpb0;
    end
    assign q_a  = rpa1;
    assign q_b2 = rpb1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word_a(input int idx);
        return 16'(((BASE_A + idx) % 1024) + 100);
    endfunction

    // Frame-level model for instance A: word k of a frame is mem[BASE+k],
    // and (issued - accepted) is exactly what occupies the FIFO plus flight.
    bit          m_busy = 0, m_done = 0;
    int          issued = 0, accepted = 0;
    int          n_rden = 0, n_accept = 0, done_count = 0, n_frames = 0;
    int          start_cyc = 0, first_valid_cyc = -1, done_cyc = 0;
    int          first_acc_cyc = -1, last_acc_cyc = 0;
    logic [15:0] acc_log [16];

    // Compare DUT A against the model every cycle
    always @(negedge clock) begin
        bit nb, nd;
        if (reset) begin
            check("rst_busy", busy_a, 0);
            check("rst_done", done_a, 0);
            check("rst_rden", rden_a, 0);
            check("rst_valid", valid_a, 0);
            check("rst_data", data_a, 0);
            check("rst_addr", addr_a, BASE_A);
            m_busy = 0; m_done = 0; issued = 0; accepted = 0;
        end else begin
            check("busy", busy_a, m_busy);
            check("done", done_a, m_done);
            check("wren", wren_a, 0);
            if (rden_a) begin
                check("rd_legal", (m_busy && !m_done && issued < N_A), 1);
                check("rd_addr", addr_a, (BASE_A + issued) % 1024);
                check("credit", (issued - accepted) < DEPTH, 1);
                issued++;
                n_rden++;
            end
            if (valid_a) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("valid_legal", (m_busy && accepted < issued), 1);
                check("data", data_a, exp_word_a(accepted));
                if (ready_a) begin
                    if (n_accept < 16) acc_log[n_accept] = data_a;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    last_acc_cyc = cyc;
                    accepted++;
                    n_accept++;
                end
            end
            if (done_a) begin
                done_count++;
                done_cyc = cyc;
            end
            nb = m_busy; nd = m_done;
            if (m_done) begin
                nb = 0; nd = 0;
            end else if (!m_busy && start_a) begin
                nb = 1; issued = 0; accepted = 0;
                start_cyc = cyc + 1;
                n_frames++;
            end else if (m_busy && valid_a && ready_a && accepted == N_A) begin
                nd = 1;
            end
            m_busy = nb; m_done = nd;
        end
    end

    // Log instance B traffic
    int          nb_rd = 0, nb_acc = 0, nb_done = 0;
    logic [3:0]  addr_log_b [8];
    logic [15:0] data_log_b [8];
    always @(negedge clock) begin
        if (!reset) begin
            if (rden_b2) begin
                if (nb_rd < 8) addr_log_b[nb_rd] = addr_b;
                nb_rd++;
            end
            if (valid_b && ready_b) begin
                if (nb_acc < 8) data_log_b[nb_acc] = data_b;
                nb_acc++;
            end
            if (done_b) nb_done++;
        end
    end

    task automatic clear_logs();
        n_rden = 0; n_accept = 0; first_valid_cyc = -1; first_acc_cyc = -1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_count < target && k < budget) begin
            @(posedge clock);
            k++;
        end
        check({name, "_timeout"}, done_count >= target, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int d0, f0, k;
        reset = 1'b1; start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("init_busy", busy_a, 0);
        check("init_valid", valid_a, 0);
        check("init_addr_b", addr_b, 14);
        check("init_wren_b", wren_b2, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Full-rate frame
        clear_logs(); d0 = done_count;
        pulse_start_a();
        wait_done(d0 + 1, 40, "t1");
        check("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
        check("t1_done_lat", done_cyc - start_cyc, 11);
        check("t1_rden", n_rden, 8);
        check("t1_accept", n_accept, 8);
        check("t1_word0", acc_log[0], 100);
        check("t1_word7", acc_log[7], 107);
        check("t1_back_to_back", last_acc_cyc - first_acc_cyc, 7);
        check("t1_idle", busy_a, 0);

        // Ready toggling 1,0,0,1
        clear_logs(); d0 = done_count;
        start_a = 1'b1;
        k = 0;
        while (done_count < d0 + 1 && k < 200) begin
            ready_a = pat[k % 4];
            @(posedge clock); #1;
            start_a = 1'b0;
            k++;
        end
        check("t2_timeout", done_count >= d0 + 1, 1);
        ready_a = 1'b1;
        check("t2_accept", n_accept, 8);
        for (int i = 0; i < 8; i++) check("t2_word", acc_log[i], 100 + i);
        @(posedge clock); #1;

        // Stall for 20 cycles: the credit limit holds issue at FIFO_DEPTH
        clear_logs(); d0 = done_count;
        ready_a = 1'b0;
        pulse_start_a();
        repeat (20) @(posedge clock);
        #1;
        check("t3_rden_stalled", n_rden, 4);
        check("t3_no_accept", n_accept, 0);
        check("t3_valid", valid_a, 1);
        check("t3_rden_low", rden_a, 0);
        ready_a = 1'b1;
        wait_done(d0 + 1, 40, "t3");
        check("t3_rden_total", n_rden, 8);
        check("t3_accept", n_accept, 8);
        check("t3_done_after_last", done_cyc - last_acc_cyc, 1);

        // Reset mid-frame after 3 words
        clear_logs(); d0 = done_count;
        pulse_start_a();
        k = 0;
        while (n_accept < 3 && k < 40) begin
            @(posedge clock);
            k++;
        end
        check("t4_reach3", n_accept, 3);
        #1 reset = 1'b1;
        #1;
        check("t4_busy", busy_a, 0);
        check("t4_valid", valid_a, 0);
        check("t4_rden", rden_a, 0);
        check("t4_data", data_a, 0);
        check("t4_addr", addr_a, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("t4_no_done", done_count, d0);
        clear_logs();
        pulse_start_a();
        wait_done(d0 + 1, 40, "t4");
        check("t4_accept", n_accept, 8);
        check("t4_word0", acc_log[0], 100);
        check("t4_word7", acc_log[7], 107);

        // start held high: one frame, then a second frame from the re-sample
        d0 = done_count; f0 = n_frames;
        start_a = 1'b1;
        wait_done(d0 + 1, 40, "t5a");
        start_a = 1'b0;
        check("t5_frames_two", n_frames, f0 + 2);
        clear_logs();
        k = 0;
        while (n_rden < 8 && k < 40) begin
            @(posedge clock);
            k++;
        end
        #1 start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        wait_done(d0 + 2, 40, "t5b");
        repeat (10) @(posedge clock);
        #1;
        check("t5_done_count", done_count, d0 + 2);
        check("t5_frames", n_frames, f0 + 2);
        check("t5_accept", n_accept, 8);
        check("t5_idle", busy_a, 0);

        // Instance B: address wrap 14,15,0,1
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        k = 0;
        while (nb_done < 1 && k < 40) begin
            @(posedge clock);
            k++;
        end
        check("t6_timeout", nb_done >= 1, 1);
        repeat (3) @(posedge clock);
        #1;
        check("t6_rd", nb_rd, 4);
        check("t6_addr0", addr_log_b[0], 14);
        check("t6_addr1", addr_log_b[1], 15);
        check("t6_addr2", addr_log_b[2], 0);
        check("t6_addr3", addr_log_b[3], 1);
        check("t6_acc", nb_acc, 4);
        check("t6_data0", data_log_b[0], 49);
        check("t6_data1", data_log_b[1], 52);
        check("t6_data2", data_log_b[2], 7);
        check("t6_data3", data_log_b[3], 10);
        check("t6_done", nb_done, 1);
        check("t6_idle", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fmap_buf_reader.md
Name: fmap_buf_reader

Overview:
- Read-side engine for the feature-map dual-port RAM that the conv/no-pool writer fills through port A.
- After a layer's results are stored, it streams NUM_WORDS words out of RAM port B in address order, starting at BASE_ADDR.
- Output is a valid/ready stream feeding the next layer or the result unloader.
- Fixed RAM read latency is absorbed by a small output FIFO, gated by credit-based issue, so back-pressure never drops data.

Parameters:
- DATA_WIDTH, 16: word width of RAM and stream.
- POOL_ADDR_WIDTH, 10: RAM address width.
- NUM_WORDS, 784: words read per frame; legal range 1..2^POOL_ADDR_WIDTH.
- BASE_ADDR, 0: first read address.
- RD_LATENCY, 2: cycles from rden_b/address_b_t to q_b valid; legal range 1..4.
- FIFO_DEPTH, 4: output FIFO entries; must be >= RD_LATENCY+1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin frame readout; sampled only in IDLE.
- busy  out  1  high from start acceptance through the done cycle.
- done  out  1  one-cycle pulse when the last word is accepted by the sink.
- rden_b  out  1  RAM port B read enable.
- wren_b  out  1  constant 0.
- address_b_t  out  POOL_ADDR_WIDTH  RAM port B read address.
- q_b  in  DATA_WIDTH  RAM port B read data, valid RD_LATENCY cycles after rden_b.
- data_out  out  DATA_WIDTH  stream data (FIFO head).
- data_valid  out  1  FIFO non-empty.
- data_ready  in  1  sink accepts data_out when data_valid && data_ready.

Behaviour:
- Reset values: busy=0, done=0, rden_b=0, address_b_t=BASE_ADDR, data_out=0, data_valid=0; internal state IDLE, all counters 0, FIFO empty, latency pipe cleared.
- Reset asserted mid-frame aborts immediately: in-flight reads are discarded, FIFO is flushed, no done pulse.
- States:
  - IDLE: start=1 -> ISSUE; busy goes 1 the next cycle. Load address to BASE_ADDR, issue_cnt=0, pop_cnt=0.
  - ISSUE: each cycle where (fifo_count + inflight) < FIFO_DEPTH, drive rden_b=1 with current address_b_t. Then address increments mod 2^POOL_ADDR_WIDTH (wraps to 0 past all-ones) and issue_cnt increments. When the NUM_WORDS-th read is issued -> DRAIN.
  - DRAIN: no reads issued. When pop_cnt reaches NUM_WORDS -> DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0. start during ISSUE, DRAIN or DONE is ignored.
- rden_b is combinational from state plus the credit check, or registered with matching address; either way rden_b and address_b_t must be coincident on the same cycle.
- inflight: an RD_LATENCY-deep shift register of issue flags. When a flag exits, q_b is pushed into the FIFO in that cycle.
- The credit rule guarantees the FIFO never overflows. Push and pop in the same cycle leave fifo_count unchanged.
- Pop when data_valid && data_ready; pop_cnt increments.
- data_out is the FIFO head. It is stable while data_valid=1 and data_ready=0.
- Throughput: with data_ready held at 1, one word per cycle.
  - First data_valid occurs RD_LATENCY+1 cycles after the start-sampling edge.
  - done occurs NUM_WORDS+RD_LATENCY+1 cycles after start, ±1 for registered rden.
- NUM_WORDS=1: a single read is issued, then DRAIN, then DONE.
- Address wrap: BASE_ADDR + NUM_WORDS may exceed the address range; addresses wrap silently.

Test Plan:
- NUM_WORDS=8, BASE_ADDR=0, RAM preloaded with mem[i]=i+100, data_ready=1: stream is 100..107 on consecutive cycles, rden_b high for 8 cycles at addresses 0..7, one done pulse, busy falls after done.
- Same setup, data_ready toggled 1,0,0,1 repeating: all 8 words in order with no duplicates or drops. (fifo_count + inflight) never exceeds 4. data_out is held stable while stalled.
- data_ready=0 for 20 cycles after start: exactly FIFO_DEPTH=4 reads issued, then rden_b stays low. On ready=1, the remaining 4 words are issued and delivered; done follows the last acceptance.
- POOL_ADDR_WIDTH=4, BASE_ADDR=14, NUM_WORDS=4: addresses 14,15,0,1 are read and data is in that order.
- reset pulsed mid-frame after 3 words accepted: all outputs return to reset values within the reset cycle, no done pulse. A new start afterwards reads all NUM_WORDS from BASE_ADDR.
- start held high through the entire frame, and start pulse in DRAIN: exactly one frame and one done per accepted start. A start re-sampled in IDLE after DONE begins a second, identical frame.
